// File: rtl/cursor_uart_rx_pkg.sv
// Shared constants, byte0 field layout and byte FSM state type for the
// cursor UART receive path.
package cursor_uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 868;
    localparam int PKT_BYTES        = 3;

    localparam int LEFT_BIT  = 0;
    localparam int RIGHT_BIT = 1;
    localparam int RSVD_MSB  = 7;
    localparam int RSVD_LSB  = 2;

    typedef enum logic [1:0] {
        BYTE_IDLE,
        BYTE_START,
        BYTE_DATA,
        BYTE_STOP
    } byte_state_e;

endpackage

// File: rtl/cursor_uart_rx_byte.sv
// 8N1 byte receiver: rx synchroniser, start-edge detect, bit sampling FSM
// and frame error detection.
module cursor_uart_rx_byte
    import cursor_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_done,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       start_edge,
    output logic       idle
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q, rx_s_q, rx_prev_q;
    byte_state_e      state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic             fall;

    // Synchroniser and edge history reset high so releasing reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall = rx_prev_q & ~rx_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BYTE_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        byte_done   = 1'b0;
        case (state_q)
            BYTE_IDLE: begin
                clk_cnt_d = '0;
                if (fall) state_d = BYTE_START;
            end
            BYTE_START: begin
                if (clk_cnt_q == HALF_CNT) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s_q ? BYTE_IDLE : BYTE_DATA;
                end
            end
            BYTE_DATA: begin
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = BYTE_STOP;
                end
            end
            BYTE_STOP: begin
                // Leave at mid-stop so a start edge one stop period later is still seen.
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d   = '0;
                    state_d     = BYTE_IDLE;
                    byte_done   = rx_s_q;
                    frame_err_d = ~rx_s_q;
                end
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = BYTE_IDLE;
            end
        endcase
    end

    assign data       = shift_q;
    assign frame_err  = frame_err_q;
    assign idle       = (state_q == BYTE_IDLE);
    assign start_edge = idle & fall;

endmodule

// File: rtl/cursor_uart_rx.sv
// Cursor UART receiver top: assembles 3-byte click/dx/dy packets from the
// byte receiver and flags sync errors and inter-byte timeouts.
module cursor_uart_rx
    import cursor_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       pkt_valid,
    output logic       right_click,
    output logic       left_click,
    output logic [7:0] dx,
    output logic [7:0] dy,
    output logic       frame_err,
    output logic       sync_err,
    output logic       busy
);

    localparam int GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_LIMIT);

    logic       byte_done, byte_frame_err, start_edge, byte_idle;
    logic [7:0] byte_data;

    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       byte0_q, byte0_d;
    logic [7:0]       dx_hold_q, dx_hold_d;
    logic             right_q, right_d, left_q, left_d;
    logic [7:0]       dx_q, dx_d, dy_q, dy_d;
    logic             pkt_valid_q, pkt_valid_d;
    logic             sync_err_q, sync_err_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    cursor_uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .byte_done (byte_done),
        .data      (byte_data),
        .frame_err (byte_frame_err),
        .start_edge(start_edge),
        .idle      (byte_idle)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q  <= '0;
            byte0_q     <= '0;
            dx_hold_q   <= '0;
            right_q     <= 1'b0;
            left_q      <= 1'b0;
            dx_q        <= '0;
            dy_q        <= '0;
            pkt_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            gap_q       <= '0;
        end else begin
            byte_idx_q  <= byte_idx_d;
            byte0_q     <= byte0_d;
            dx_hold_q   <= dx_hold_d;
            right_q     <= right_d;
            left_q      <= left_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            pkt_valid_q <= pkt_valid_d;
            sync_err_q  <= sync_err_d;
            gap_q       <= gap_d;
        end
    end

    always_comb begin
        byte_idx_d  = byte_idx_q;
        byte0_d     = byte0_q;
        dx_hold_d   = dx_hold_q;
        right_d     = right_q;
        left_d      = left_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        pkt_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        gap_d       = gap_q;

        // Gap counter only runs between bytes of a partial packet and saturates at the limit.
        if (byte_idx_q == 2'd0 || start_edge) begin
            gap_d = '0;
        end else if (byte_idle && gap_q != GAP_MAX) begin
            gap_d = gap_q + 1'b1;
        end

        if (byte_frame_err) begin
            byte_idx_d = 2'd0;
        end else if (byte_idx_q != 2'd0 && byte_idle && gap_q == GAP_MAX) begin
            sync_err_d = 1'b1;
            byte_idx_d = 2'd0;
            gap_d      = '0;
        end else if (byte_done) begin
            case (byte_idx_q)
                2'd0: begin
                    if (byte_data[RSVD_MSB:RSVD_LSB] != '0) begin
                        sync_err_d = 1'b1;
                    end else begin
                        byte0_d    = byte_data;
                        byte_idx_d = 2'd1;
                    end
                end
                2'd1: begin
                    dx_hold_d  = byte_data;
                    byte_idx_d = 2'd2;
                end
                2'd2: begin
                    right_d     = byte0_q[RIGHT_BIT];
                    left_d      = byte0_q[LEFT_BIT];
                    dx_d        = dx_hold_q;
                    dy_d        = byte_data;
                    pkt_valid_d = 1'b1;
                    byte_idx_d  = 2'd0;
                end
                default: byte_idx_d = 2'd0;
            endcase
        end
    end

    assign pkt_valid   = pkt_valid_q;
    assign right_click = right_q;
    assign left_click  = left_q;
    assign dx          = dx_q;
    assign dy          = dy_q;
    assign frame_err   = byte_frame_err;
    assign sync_err    = sync_err_q;
    assign busy        = ~byte_idle | (byte_idx_q != 2'd0);

endmodule

// File: tb/tb_cursor_uart_rx.sv
// Scoreboard bench for cursor_uart_rx: stimulus queues expected pulses,
// a monitor pops and compares whenever the DUT emits one.
module tb_cursor_uart_rx;

    localparam int CPB = 16;
    localparam int TOB = 20;
    localparam int EV_PKT   = 0;
    localparam int EV_FRAME = 1;
    localparam int EV_SYNC  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       pkt_valid, right_click, left_click, frame_err, sync_err, busy;
    logic [7:0] dx, dy;

    typedef struct {
        int          kind;
        logic [17:0] val;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    cursor_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .pkt_valid  (pkt_valid),
        .right_click(right_click),
        .left_click (left_click),
        .dx         (dx),
        .dy         (dy),
        .frame_err  (frame_err),
        .sync_err   (sync_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic pushEvt(input int kind, input logic rc, input logic lc,
                           input logic [7:0] ex, input logic [7:0] ey);
        exp_t e;
        e.kind = kind;
        e.val  = {rc, lc, ex, ey};
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stopBit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idleBits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (pkt_valid || frame_err || sync_err)) begin
            int   kind;
            exp_t e;
            kind = pkt_valid ? EV_PKT : (frame_err ? EV_FRAME : EV_SYNC);
            checkOutput("pulse_exclusive",
                        32'(int'(pkt_valid) + int'(frame_err) + int'(sync_err)), 32'd1);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_pulse_kind", 32'(kind), 32'hFFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("event_kind", 32'(kind), 32'(e.kind));
                if (kind == EV_PKT)
                    checkOutput("pkt_fields", {14'b0, right_click, left_click, dx, dy}, {14'b0, e.val});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    {11'b0, pkt_valid, frame_err, sync_err, right_click, left_click, dx, dy, busy}, 32'd0);
        rst_n = 1'b1;
        idleBits(2);

        $display("[TB] test 1: basic packet");
        pushEvt(EV_PKT, 1'b1, 1'b0, 8'h05, 8'hFB);
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h05, 1'b1);
        applyStimulus(8'hFB, 1'b1);
        idleBits(2);
        checkOutput("t1_busy_idle", {31'b0, busy}, 32'd0);

        $display("[TB] test 2: false start");
        rx = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t2_busy_in_start", {31'b0, busy}, 32'd1);
        idleBits(2);
        checkOutput("t2_busy_idle", {31'b0, busy}, 32'd0);
        checkOutput("t2_hold", {14'b0, right_click, left_click, dx, dy}, {14'b0, 1'b1, 1'b0, 8'h05, 8'hFB});

        $display("[TB] test 3: frame error then recovery");
        applyStimulus(8'h01, 1'b1);
        pushEvt(EV_FRAME, 1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(8'h33, 1'b0);
        idleBits(2);
        checkOutput("t3_idx_cleared", {31'b0, busy}, 32'd0);
        pushEvt(EV_PKT, 1'b0, 1'b1, 8'h7F, 8'h80);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h7F, 1'b1);
        applyStimulus(8'h80, 1'b1);
        idleBits(2);

        $display("[TB] test 4: reserved bits set in byte0");
        pushEvt(EV_SYNC, 1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(8'h41, 1'b1);
        pushEvt(EV_PKT, 1'b0, 1'b0, 8'h10, 8'h20);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h10, 1'b1);
        applyStimulus(8'h20, 1'b1);
        idleBits(2);

        $display("[TB] test 5: inter-byte timeout");
        pushEvt(EV_SYNC, 1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h11, 1'b1);
        checkOutput("t5_busy_partial", {31'b0, busy}, 32'd1);
        idleBits(21);
        checkOutput("t5_busy_after_timeout", {31'b0, busy}, 32'd0);
        checkOutput("t5_hold", {14'b0, right_click, left_click, dx, dy}, {14'b0, 1'b0, 1'b0, 8'h10, 8'h20});
        pushEvt(EV_PKT, 1'b0, 1'b0, 8'h22, 8'h33);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h33, 1'b1);
        idleBits(2);

        $display("[TB] test 6: reset mid-packet");
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h01, 1'b1);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rx    = 1'b1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_reset_outputs",
                    {11'b0, pkt_valid, frame_err, sync_err, right_click, left_click, dx, dy, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idleBits(2);
        pushEvt(EV_PKT, 1'b1, 1'b1, 8'h01, 8'hFF);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        pushEvt(EV_PKT, 1'b0, 1'b0, 8'h02, 8'hFE);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'hFE, 1'b1);
        idleBits(2);

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cursor_uart_rx.md
Name: cursor_uart_rx

Overview:
- Receive side of the cursor UART link: deserialises 8N1 frames from a single rx line and reassembles 3-byte cursor packets.
- Packet order: byte0 = {6'b0, right_click, left_click}, byte1 = dx, byte2 = dy.
- Drives click/dx/dy registers plus a one-cycle packet strobe for the host-side cursor logic.
- Detects framing errors, packet sync errors and inter-byte timeouts.

Parameters:
- CLKS_PER_BIT, 868: clocks per bit period (100 MHz / 115200 baud). Must be >= 4.
- TIMEOUT_BITS, 20: idle bit periods allowed between bytes of one packet before the partial packet is abandoned.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock domain; reset is asynchronous and active-low.
- rx  in  1  serial input, asynchronous, idle high.
- pkt_valid  out  1  one-cycle pulse when a complete packet is latched.
- right_click  out  1  byte0[1] of the last good packet.
- left_click  out  1  byte0[0] of the last good packet.
- dx  out  8 signed  byte1 of the last good packet.
- dy  out  8 signed  byte2 of the last good packet.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- sync_err  out  1  one-cycle pulse: byte0[7:2] nonzero, or inter-byte timeout.
- busy  out  1  high while a byte is in flight or a packet is partially assembled.

Behaviour:
- Reset (async assert, sync release):
  - sync flops and edge-history flop = 1, so no false edge occurs on release.
  - All outputs = 0, byte FSM = IDLE, byte_idx = 0, all counters = 0.
  - Assertion mid-frame or mid-packet abandons everything; no pulse is emitted.
- Input conditioning: 2-flop synchroniser gives rx_s. Start is detected only on a falling edge (previous rx_s = 1, current rx_s = 0).
- Byte FSM states: IDLE, START, DATA, STOP. Counter clk_cnt runs 0..CLKS_PER_BIT-1.
  - IDLE: on a falling edge, go to START with clk_cnt = 0.
  - START: at clk_cnt == CLKS_PER_BIT/2-1, sample rx_s.
    - rx_s = 1: false start; go to IDLE, no error.
    - rx_s = 0: go to DATA with clk_cnt = 0 and bit count = 0.
  - DATA: at clk_cnt == CLKS_PER_BIT-1, shift rx_s in LSB-first. After the 8th bit, go to STOP.
  - STOP: at clk_cnt == CLKS_PER_BIT-1, sample rx_s and go to IDLE in the same cycle (mid-stop bit), so a start edge arriving exactly one stop period later is caught.
    - rx_s = 1: byte_done.
    - rx_s = 0: frame_err pulse, byte discarded, byte_idx = 0. Re-arm needs a fresh falling edge; a held-low break line produces no further frames.
- Packet assembly, on byte_done:
  - byte_idx 0, byte[7:2] != 0: sync_err pulse, byte dropped, byte_idx stays 0.
  - byte_idx 0, byte[7:2] == 0: hold byte, byte_idx = 1.
  - byte_idx 1: hold byte as dx, byte_idx = 2.
  - byte_idx 2: update right_click, left_click, dx, dy together; pkt_valid = 1 on the next cycle; byte_idx = 0.
  - Latency from stop-bit sample of byte2 to pkt_valid = 1 clock.
  - Outputs hold until the next good packet; a partial packet never disturbs them.
- Timeout:
  - While byte_idx != 0 and the byte FSM is in IDLE, a gap counter increments; it clears on every start edge.
  - On reaching TIMEOUT_BITS*CLKS_PER_BIT: sync_err pulse, byte_idx = 0.
  - Counter width = clog2(TIMEOUT_BITS*CLKS_PER_BIT + 1); it saturates and never wraps.
- Exclusivity: frame_err, sync_err and pkt_valid never assert in the same cycle, because timeout only counts in IDLE and byte_done takes exactly one path.
- busy = (byte FSM != IDLE) OR (byte_idx != 0).

Decomposition:
- Package cursor_uart_pkg holds:
  - CLKS_PER_BIT default, PKT_BYTES = 3.
  - Byte0 field positions: LEFT_BIT = 0, RIGHT_BIT = 1, RSVD_MSB = 7, RSVD_LSB = 2.
  - Byte FSM state enum.
- One sub-module, cursor_uart_rx_byte: synchroniser, byte FSM and frame_err. Outputs byte_done and data[7:0] to the packet assembler in the top.

Test Plan (CLKS_PER_BIT = 16, TIMEOUT_BITS = 20):
1. Frames 0x02, 0x05, 0xFB back-to-back with one stop bit each -> single pkt_valid; right_click = 1, left_click = 0, dx = +5, dy = -5; no error pulses.
2. rx low for 4 clocks, then high -> no byte_done, no error, outputs unchanged, busy returns to 0.
3. 0x01, then byte1 with stop bit forced 0 -> frame_err pulse, no pkt_valid. Then 0x01, 0x7F, 0x80 -> left_click = 1, dx = 127, dy = -128.
4. 0x41, 0x00, 0x10, 0x20 -> one sync_err at the 0x41 stop sample, then pkt_valid with clicks = 0, dx = 0x10, dy = 0x20.
5. 0x03, 0x11, idle 21 bit periods, then 0x00, 0x22, 0x33 -> sync_err at 320 idle clocks; pkt_valid with dx = 0x22, dy = 0x33; previous outputs untouched until then.
6. rst_n pulsed low mid-byte2 -> all outputs 0 immediately, no pkt_valid. Then two packets 0x03,0x01,0xFF and 0x00,0x02,0xFE -> two pkt_valid pulses with matching values.
